regfile_write_scheduler: RTL and testbench

Shares the single register-file write port between two writeback requesters: port A (single-cycle ALU writeback) and port B (multicycle unit, e.g. load/multiply). Arbitrates with round-robin priority and drives the regfile's WriteRegister/WriteData/RegWrite from a registered output stage. Keeps a 32-entry pending-write scoreboard so the decode stage can stall on read-after-write hazards. Sits between the writeback sources and the regfile write port.

---
 rtl/regfile_write_scheduler.sv | 76 +++++++
 tb/tb_regfile_write_scheduler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - round-robin arbiter for the shared regfile write port with RAW scoreboard
module regfile_write_scheduler (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqA,
  input  logic        ReqB,
  input  logic [4:0]  RegA,
  input  logic [4:0]  RegB,
  input  logic [31:0] DataA,
  input  logic [31:0] DataB,
  output logic        GntA,
  output logic        GntB,
  input  logic        Reserve,
  input  logic [4:0]  ReserveReg,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        Stall1,
  output logic        Stall2,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite
);

  logic        last_b;
  logic [31:0] pending;
  logic [31:0] pending_next;
  logic        accept;
  logic [4:0]  win_reg;
  logic [31:0] win_data;

  // A wins a contest only when B took the previous grant.
  always_comb begin
    GntA = 1'b0;
    GntB = 1'b0;
    if (!Reset) begin
      if (ReqA && (!ReqB || last_b)) GntA = 1'b1;
      else if (ReqB)                 GntB = 1'b1;
    end
  end

  assign accept   = GntA | GntB;
  assign win_reg  = GntB ? RegB  : RegA;
  assign win_data = GntB ? DataB : DataA;

  // Set after clear so a same-register reservation (younger) survives the retiring write.
  always_comb begin
    pending_next = pending;
    if (accept && (win_reg != 5'd0))
      pending_next[win_reg] = 1'b0;
    if (Reserve && (ReserveReg != 5'd0))
      pending_next[ReserveReg] = 1'b1;
    pending_next[0] = 1'b0;
  end

  assign Stall1 = pending[ReadRegister1];
  assign Stall2 = pending[ReadRegister2];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_b        <= 1'b1;
      pending       <= 32'd0;
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
    end else begin
      pending  <= pending_next;
      RegWrite <= accept && (win_reg != 5'd0);
      if (accept) begin
        WriteRegister <= win_reg;
        WriteData     <= win_data;
        last_b        <= GntB;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - directed and random checks of regfile_write_scheduler against a behavioural model
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic [4:0]  reg_a, reg_b;
  logic [31:0] data_a, data_b;
  logic        gnt_a, gnt_b;
  logic        reserve;
  logic [4:0]  reserve_reg;
  logic [4:0]  rr1, rr2;
  logic        stall1, stall2;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        reg_write;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_last_b;
  bit          m_pend [32];
  bit          m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  bit          last_wa, last_wb;

  regfile_write_scheduler dut (
    .Clk(clk), .Reset(rst),
    .ReqA(req_a), .ReqB(req_b), .RegA(reg_a), .RegB(reg_b),
    .DataA(data_a), .DataB(data_b), .GntA(gnt_a), .GntB(gnt_b),
    .Reserve(reserve), .ReserveReg(reserve_reg),
    .ReadRegister1(rr1), .ReadRegister2(rr2),
    .Stall1(stall1), .Stall2(stall2),
    .WriteRegister(write_register), .WriteData(write_data), .RegWrite(reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Caller sets inputs; this checks grants, clocks once, updates the model and checks outputs.
  task automatic step();
    bit wa, wb;
    #1;
    wa = 1'b0;
    wb = 1'b0;
    if (!rst) begin
      if (req_a && req_b) begin
        if (m_last_b) wa = 1'b1;
        else          wb = 1'b1;
      end else if (req_a) wa = 1'b1;
      else if (req_b)     wb = 1'b1;
    end
    check("gnt_a", {31'd0, gnt_a}, {31'd0, wa});
    check("gnt_b", {31'd0, gnt_b}, {31'd0, wb});
    @(posedge clk);
    if (rst) begin
      m_last_b = 1'b1;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_we = 1'b0;
      m_wr = 5'd0;
      m_wd = 32'd0;
    end else begin
      m_we = 1'b0;
      if (wa || wb) begin
        m_wr     = wb ? reg_b : reg_a;
        m_wd     = wb ? data_b : data_a;
        m_we     = (m_wr != 5'd0);
        m_last_b = wb;
        if (m_wr != 5'd0) m_pend[m_wr] = 1'b0;
      end
      if (reserve && reserve_reg != 5'd0) m_pend[reserve_reg] = 1'b1;
    end
    #1;
    check("reg_write", {31'd0, reg_write}, {31'd0, m_we});
    check("write_register", {27'd0, write_register}, {27'd0, m_wr});
    check("write_data", write_data, m_wd);
    check("stall1", {31'd0, stall1}, {31'd0, m_pend[rr1]});
    check("stall2", {31'd0, stall2}, {31'd0, m_pend[rr2]});
    last_wa = wa;
    last_wb = wb;
  endtask

  task automatic idle();
    req_a = 1'b0; req_b = 1'b0; reserve = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle();
    reg_a = 5'd0; reg_b = 5'd0; data_a = 32'd0; data_b = 32'd0;
    reserve_reg = 5'd0; rr1 = 5'd0; rr2 = 5'd0;
    m_last_b = 1'b1; m_we = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
    last_wa = 1'b0; last_wb = 1'b0;
    step(); step();
    rst = 1'b0;

    // Single A write, then idle
    req_a = 1'b1; reg_a = 5'd5; data_a = 32'h2A; step();
    idle(); step(); step();

    // Continuous contest after reset: A, B, A, B
    rst = 1'b1; step(); rst = 1'b0;
    req_a = 1'b1; reg_a = 5'd3; data_a = 32'h11;
    req_b = 1'b1; reg_b = 5'd7; data_b = 32'h22;
    repeat (4) step();
    idle(); step();

    // Reserve 9, watch stall, retire it from B
    reserve = 1'b1; reserve_reg = 5'd9; rr1 = 5'd9; step();
    reserve = 1'b0; step();
    req_b = 1'b1; reg_b = 5'd9; data_b = 32'h99; step();
    idle(); step();

    // Register 0 write and reservation are dropped
    rr1 = 5'd0; rr2 = 5'd0;
    req_a = 1'b1; reg_a = 5'd0; data_a = 32'h4; reserve = 1'b1; reserve_reg = 5'd0; step();
    idle(); step();

    // Same-edge clear and set of register 12
    rr2 = 5'd12;
    reserve = 1'b1; reserve_reg = 5'd12; step();
    req_a = 1'b1; reg_a = 5'd12; data_a = 32'hC; step();
    idle(); step();

    // Reservations and held request wiped by reset, then A wins contest
    rr1 = 5'd4; rr2 = 5'd6;
    reserve = 1'b1; reserve_reg = 5'd4; step();
    reserve_reg = 5'd6; step();
    reserve = 1'b0; req_b = 1'b1; reg_b = 5'd6; data_b = 32'h66; rst = 1'b1; step();
    rst = 1'b0; req_a = 1'b1; reg_a = 5'd4; data_a = 32'h44; step();
    idle(); step();

    // Random traffic; a requester holds its request until granted
    for (int i = 0; i < 400; i++) begin
      if (last_wa || !req_a) begin
        req_a  = ($urandom_range(0, 2) != 0);
        reg_a  = 5'($urandom_range(0, 31));
        data_a = $urandom;
      end
      if (last_wb || !req_b) begin
        req_b  = ($urandom_range(0, 2) != 0);
        reg_b  = 5'($urandom_range(0, 31));
        data_b = $urandom;
      end
      reserve     = ($urandom_range(0, 2) == 0);
      reserve_reg = 5'($urandom_range(0, 31));
      rr1         = ($urandom_range(0, 1) == 0) ? reserve_reg : 5'($urandom_range(0, 31));
      rr2         = ($urandom_range(0, 1) == 0) ? reg_b : 5'($urandom_range(0, 31));
      rst         = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
